// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-side signals of the ALU command sequencer.
// The master side offers commands, drives the ALU result and consumes responses.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] cmd_op;
  logic [3:0] cmd_tag;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_tag;
  logic       rsp_divz;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_tag, rsp_divz
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_tag, rsp_divz
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a FIFO and runs them one at a time through an external
// fixed-latency ALU, returning each result with its tag in acceptance order.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_cmd_sequencer_if.slave       bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [22:0]     fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [2:0]      wait_reg, wait_next;
  logic [7:0]      alu_a_reg, alu_a_next;
  logic [7:0]      alu_b_reg, alu_b_next;
  logic [2:0]      alu_op_reg, alu_op_next;
  logic [7:0]      rsp_data_reg, rsp_data_next;
  logic [3:0]      rsp_tag_reg, rsp_tag_next;
  logic            rsp_divz_reg, rsp_divz_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic            cmd_ready_int;
  logic            push, pop;
  logic [22:0]     head;

  // Readiness depends on occupancy only, so a same-cycle pop never frees a full FIFO.
  assign cmd_ready_int = (count_reg < CW'(DEPTH));
  assign push          = bus.cmd_valid && cmd_ready_int;
  assign pop           = (state_reg == IDLE) && (count_reg != '0);
  assign head          = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_reg      <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= '0;
      rsp_data_reg  <= '0;
      rsp_tag_reg   <= '0;
      rsp_divz_reg  <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_reg      <= wait_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      alu_op_reg    <= alu_op_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_tag_reg   <= rsp_tag_next;
      rsp_divz_reg  <= rsp_divz_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_next      = wait_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    alu_op_next    = alu_op_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_tag_next   = rsp_tag_reg;
    rsp_divz_next  = rsp_divz_reg;
    rsp_valid_next = rsp_valid_reg;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          alu_a_next    = head[22:15];
          alu_b_next    = head[14:7];
          alu_op_next   = head[6:4];
          rsp_tag_next  = head[3:0];
          rsp_divz_next = (head[6:4] == 3'b011) && (head[14:7] == 8'h00);
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        wait_next  = 3'(ALU_LAT);
        state_next = WAIT;
      end
      WAIT: begin
        wait_next = wait_reg - 3'd1;
        // The ALU result is valid during the cycle before the counter hits zero.
        if (wait_reg == 3'd1) begin
          rsp_data_next  = bus.alu_result;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.alu_op    = alu_op_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_tag   = rsp_tag_reg;
  assign bus.rsp_divz  = rsp_divz_reg;
  assign busy          = (state_reg != IDLE);
  assign fifo_count    = count_reg;
endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth in entries (power of 2, 2..16).
REQ-002 Parameter ALU_LAT, default 1, cycles from ALU input sample edge to valid alu_result (1..4).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO can accept a command.
REQ-007 cmd_a, cmd_b  input  8 each  operands.
REQ-008 cmd_op  input  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 a>b.
REQ-009 cmd_tag  input  4  opaque tag returned with the response.
REQ-010 alu_a, alu_b  output  8 each  registered operands to the ALU.
REQ-011 alu_op  output  3  registered opcode to the ALU.
REQ-012 alu_result  input  8  registered ALU result.
REQ-013 rsp_valid  output  1  response held.
REQ-014 rsp_ready  input  1  response consumer ready.
REQ-015 rsp_data  output  8  captured alu_result.
REQ-016 rsp_tag  output  4  tag of the responded command.
REQ-017 rsp_divz  output  1  command was opcode 011 with b == 0.
REQ-018 busy  output  1  high when the FSM is not IDLE.
REQ-019 fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-020 Command accepted on a rising edge when cmd_valid && cmd_ready; entry {a,b,op,tag} written at the FIFO tail.
REQ-021 cmd_ready SHALL be (fifo_count < DEPTH), from registered state only; no write when full, even if a pop occurs in the same cycle.
REQ-022 Simultaneous push and pop in one cycle SHALL leave fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-023 FSM states: IDLE, ISSUE, WAIT, RESP; one command in flight at a time.
REQ-024 IDLE: if fifo_count > 0, the next edge pops the head, loads alu_a/alu_b/alu_op with it, latches tag and divz, and moves to ISSUE; otherwise stays in IDLE.
REQ-025 IDLE SHALL not pop a command written on the same edge; that command is seen one cycle later.
REQ-026 ISSUE: lasts exactly one cycle (ALU samples its inputs at the exit edge), then WAIT with the wait counter set to ALU_LAT.
REQ-027 WAIT: the counter decrements each edge; on the edge where it reaches zero, alu_result is captured into rsp_data, rsp_valid is set to 1 and the FSM moves to RESP.
REQ-028 With ALU_LAT=1 and an empty, idle block, rsp_valid SHALL rise 3 edges after the command's acceptance edge.
REQ-029 RESP: rsp_data, rsp_tag and rsp_divz are held stable while rsp_valid && !rsp_ready; on the edge where rsp_ready is sampled high, rsp_valid clears and the FSM moves to IDLE.
REQ-030 alu_a/alu_b/alu_op SHALL hold their values from ISSUE until the next IDLE->ISSUE load.
REQ-031 rsp_divz = 1 iff op == 011 and b == 8'h00; the result is passed through unmodified, with no special-casing.
REQ-032 Responses SHALL return in command acceptance order; tags are not interpreted.
REQ-033 FIFO accepts commands in every FSM state.

Reset
REQ-034 On rst: FIFO pointers and fifo_count set to 0, FSM to IDLE, rsp_valid/rsp_divz/busy 0, rsp_data/rsp_tag 0, alu_a/alu_b/alu_op 0, wait counter 0.
REQ-035 rst asserted mid-operation (any state) SHALL discard the in-flight command and all queued commands, with no response issued.
REQ-036 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-037 Single op: push a=8'd25, b=8'd17, op=000, tag=4'h3, rsp_ready=1 -> rsp_valid 3 edges later with rsp_data=8'd42, rsp_tag=3, rsp_divz=0.
REQ-038 Fill and backpressure: push 5 commands back-to-back with rsp_ready=0 -> cmd_ready drops when fifo_count reaches 4; the 5th command is accepted only after the first pop; responses come out in order once rsp_ready=1.
REQ-039 Response hold: rsp_valid with rsp_ready=0 for 6 cycles -> rsp_data/rsp_tag stable throughout; a single handshake, then IDLE.
REQ-040 Divide by zero: a=8'd9, b=0, op=011 -> rsp_divz=1, rsp_data equal to the ALU's output; a following op=111 with a=5, b=3 -> rsp_data=1, rsp_divz=0.
REQ-041 Reset mid-WAIT with 2 commands queued -> after reset fifo_count=0, rsp_valid=0, busy=0, no response ever appears.
REQ-042 Wrap-around: 12 sequential commands of op=110 with distinct tags, rsp_ready toggling -> all 12 responses correct and in tag order; pointers wrap 3 times.
